drv_mon: RTL and testbench
==========================

Name: drv_mon

Overview:
- Single-terminal driver/monitor adapter between a packet source (agent) and the shared data-bus fabric.
- Driver side: buffers agent packets in a FIFO, raises pending to the bus, and presents the head word on d_pop until the bus pops it.
- Monitor side: captures every word the bus pushes into this terminal and hands it to the checker as a one-cycle valid beat.
- One instance per bus terminal; `id` selects the terminal.

Parameters:
- width, 32, packet width in bits; [width-1:width-8] is the destination id, [width-9:0] is the payload.
- depth, 16, driver FIFO entries (power of two, >=2).
- id, 0, this terminal's id (8 bits).
- broadcast, 8'hFF, destination id meaning "all terminals".

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- agt_valid_i  in  1  agent offers a packet.
- agt_data_i  in  width  agent packet.
- agt_ready_o  out  1  FIFO not full; a write happens when agt_valid_i && agt_ready_o.
- pndng_o  out  1  FIFO non-empty (to the bus's pndng_i).
- d_pop_o  out  width  FIFO head word (to the bus's d_pop_i).
- pop_i  in  1  bus consumes the head word.
- push_i  in  1  bus delivers a word to this terminal.
- d_push_i  in  width  delivered word.
- mon_valid_o  out  1  captured word valid, one cycle.
- mon_data_o  out  width  captured word.
- mon_dest_o  out  8  destination field of the captured word.
- count_o  out  $clog2(depth)+1  FIFO occupancy.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - FIFO empty, count_o=0, pndng_o=0, d_pop_o=0, agt_ready_o=1.
  - mon_valid_o=0, mon_data_o=0, mon_dest_o=0.
- Write: an accepted packet enters the FIFO on the clock edge.
  - If the FIFO was empty, pndng_o=1 and d_pop_o=packet in the cycle after the edge (1-cycle latency).
- d_pop_o always shows the head entry and is held stable while no pop occurs; it is 0 when empty.
- Pop: pop_i=1 with pndng_o=1 removes the head at the edge. The next entry, or empty with pndng_o=0, is visible the following cycle.
- Pop while empty: ignored, no state change.
- Full: agt_ready_o=0 and further writes are not accepted.
- Simultaneous write and pop:
  - Non-empty: both occur, count unchanged.
  - Full: pop frees a slot, so the write is accepted (agt_ready_o = !full || pop_i); count unchanged.
  - Empty: only the write takes effect.
- Pointers wrap modulo depth; count_o spans 0..depth.
- Monitor: push_i=1 at an edge gives mon_valid_o=1, mon_data_o=d_push_i and mon_dest_o=d_push_i[width-1:width-8] for exactly the next cycle.
  - Back-to-back pushes give back-to-back valid beats.
  - mon_data_o holds its last value while mon_valid_o=0.
- Driver and monitor paths are independent; a push and a pop in the same cycle are both serviced.
- Reset asserted mid-operation: the FIFO is flushed immediately, and any pending monitor beat is dropped.

Optional Feature:
- Macro DRV_MON_ADDR_CHECK_EN.
- Defined:
  - Adds output mon_err_o (1 bit), asserted together with mon_valid_o when the captured destination is neither `id` nor `broadcast`.
  - Such words are still reported on mon_data_o.
- Undefined: no mon_err_o port and no comparison logic; all pushed words are reported.

Decomposition:
- Package drv_mon_pkg:
  - BROADCAST_ID constant (8'hFF).
  - ID_W=8.
  - Packet struct typedef {dest[7:0], payload} parameterised by width via a localparam default of 32.
  - Helper function get_dest().
- Sub-module drv_mon_fifo: synchronous FIFO (width, depth) with wr/rd/full/empty/count. drv_mon wires the FIFO and adds the monitor capture register.

Test Plan:
- Reset then idle -> pndng_o=0, agt_ready_o=1, count_o=0, mon_valid_o=0.
- Write 32'h0100_0005 once, pop_i=0 -> pndng_o=1 one cycle later, d_pop_o=32'h0100_0005 held for 3+ cycles.
- From that state, pulse pop_i for 1 cycle -> next cycle pndng_o=0, count_o=0, d_pop_o=0.
- d_push_i=32'd2 with a 1-cycle push_i pulse -> next cycle mon_valid_o=1, mon_data_o=2, mon_dest_o=0; the cycle after, mon_valid_o=0.
- Fill 16 words (0..15) -> agt_ready_o=0, count_o=16. Write+pop in the same cycle -> count stays 16. Then pop all -> order 1..15 followed by the new word.
- With DRV_MON_ADDR_CHECK_EN and id=0: push 32'h0300_0001 -> mon_err_o=1; push 32'hFF00_0001 -> mon_err_o=0.

Source files
------------

// File: rtl/drv_mon_pkg.sv
// Shared types and constants for the drv_mon bus-terminal adapter.
package drv_mon_pkg;

  localparam int ID_W = 8;
  localparam logic [ID_W-1:0] BROADCAST_ID = 8'hFF;
  localparam int PKT_W = 32;

  typedef struct packed {
    logic [ID_W-1:0]       dest;
    logic [PKT_W-ID_W-1:0] payload;
  } pkt_t;

  function automatic logic [ID_W-1:0] get_dest(input pkt_t p);
    return p.dest;
  endfunction

endpackage

// File: rtl/drv_mon_fifo.sv
// Synchronous FIFO for the driver path; head word is combinational, zero when empty.
module drv_mon_fifo #(
  parameter int width = 32,
  parameter int depth = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wr,
  input  logic [width-1:0]         wr_data,
  input  logic                     rd,
  output logic [width-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(depth):0]   count
);
  import drv_mon_pkg::*;

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;

  logic [width-1:0] mem [depth];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt;
  logic             wr_en, rd_en;

  assign full  = (cnt == CW'(depth));
  assign empty = (cnt == '0);
  assign count = cnt;

  // A read on a full FIFO frees the slot the same-cycle write lands in.
  assign rd_en = rd && !empty;
  assign wr_en = wr && (!full || rd_en);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(wr_en) - CW'(rd_en);
    end
  end

  // Storage needs no reset: the empty flag masks stale entries.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/drv_mon.sv
// Bus-terminal driver/monitor adapter: agent FIFO toward the bus, capture register toward the checker.
// Optional destination checking on captured words is enabled by DRV_MON_ADDR_CHECK_EN.
module drv_mon
  import drv_mon_pkg::*;
#(
  parameter int              width     = 32,
  parameter int              depth     = 16,
  parameter logic [ID_W-1:0] id        = 8'd0,
  parameter logic [ID_W-1:0] broadcast = BROADCAST_ID
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   agt_valid_i,
  input  logic [width-1:0]       agt_data_i,
  output logic                   agt_ready_o,
  output logic                   pndng_o,
  output logic [width-1:0]       d_pop_o,
  input  logic                   pop_i,
  input  logic                   push_i,
  input  logic [width-1:0]       d_push_i,
  output logic                   mon_valid_o,
  output logic [width-1:0]       mon_data_o,
  output logic [ID_W-1:0]        mon_dest_o,
`ifdef DRV_MON_ADDR_CHECK_EN
  output logic                   mon_err_o,
`endif
  output logic [$clog2(depth):0] count_o
);

  logic full, empty, wr;

  assign agt_ready_o = !full || pop_i;
  assign wr          = agt_valid_i && agt_ready_o;
  assign pndng_o     = !empty;

  drv_mon_fifo #(.width(width), .depth(depth)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .wr      (wr),
    .wr_data (agt_data_i),
    .rd      (pop_i),
    .rd_data (d_pop_o),
    .full    (full),
    .empty   (empty),
    .count   (count_o)
  );

  logic             mon_vld_q;
  logic [width-1:0] mon_data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mon_vld_q  <= 1'b0;
      mon_data_q <= '0;
    end else begin
      mon_vld_q <= push_i;
      if (push_i) mon_data_q <= d_push_i;
    end
  end

  assign mon_valid_o = mon_vld_q;
  assign mon_data_o  = mon_data_q;

  generate
    if (width == PKT_W) begin : g_dest_pkt
      assign mon_dest_o = get_dest(pkt_t'(mon_data_q));
    end else begin : g_dest_slice
      assign mon_dest_o = mon_data_q[width-1 -: ID_W];
    end
  endgenerate

`ifdef DRV_MON_ADDR_CHECK_EN
  logic [ID_W-1:0] push_dest;
  logic            mon_err_q;

  assign push_dest = d_push_i[width-1 -: ID_W];

  // Flag is computed on the incoming word so it lines up with the valid beat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) mon_err_q <= 1'b0;
    else         mon_err_q <= push_i && (push_dest != id) && (push_dest != broadcast);
  end

  assign mon_err_o = mon_err_q;
`endif

endmodule

// File: tb/tb_drv_mon.sv
// Randomized scoreboard bench for drv_mon: queue model of the FIFO plus expected-beat queue for the monitor.
module tb_drv_mon;

  localparam int        W     = 32;
  localparam int        DEPTH = 16;
  localparam logic [7:0] ID   = 8'd0;

  typedef struct {
    logic [W-1:0] data;
    logic         err;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst_ni;
  logic            agt_valid_i;
  logic [W-1:0]    agt_data_i;
  logic            agt_ready_o;
  logic            pndng_o;
  logic [W-1:0]    d_pop_o;
  logic            pop_i;
  logic            push_i;
  logic [W-1:0]    d_push_i;
  logic            mon_valid_o;
  logic [W-1:0]    mon_data_o;
  logic [7:0]      mon_dest_o;
  logic [$clog2(DEPTH):0] count_o;
`ifdef DRV_MON_ADDR_CHECK_EN
  logic            mon_err_o;
`endif

  drv_mon #(.width(W), .depth(DEPTH), .id(ID), .broadcast(8'hFF)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .agt_valid_i (agt_valid_i),
    .agt_data_i  (agt_data_i),
    .agt_ready_o (agt_ready_o),
    .pndng_o     (pndng_o),
    .d_pop_o     (d_pop_o),
    .pop_i       (pop_i),
    .push_i      (push_i),
    .d_push_i    (d_push_i),
    .mon_valid_o (mon_valid_o),
    .mon_data_o  (mon_data_o),
    .mon_dest_o  (mon_dest_o),
`ifdef DRV_MON_ADDR_CHECK_EN
    .mon_err_o   (mon_err_o),
`endif
    .count_o     (count_o)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           failures = 0;
  logic [W-1:0] fq[$];
  beat_t        mon_q[$];
  logic [W-1:0] last_mon = '0;
  logic         in_reset = 1'b1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: check driver-side state from the model, then apply the next inputs and update the model.
  task automatic step(input logic v, input logic [W-1:0] d, input logic p,
                      input logic pu, input logic [W-1:0] pd);
    int  n;
    bit  do_pop, do_wr;
    @(negedge clk);
    n = fq.size();
    chk("count", W'(count_o), W'(n));
    chk("pndng", W'(pndng_o), W'(n > 0));
    chk("d_pop", d_pop_o, (n > 0) ? fq[0] : '0);
    agt_valid_i = v; agt_data_i = d; pop_i = p; push_i = pu; d_push_i = pd;
    #1;
    chk("agt_ready", W'(agt_ready_o), W'((n < DEPTH) || p));
    do_pop = p && (n > 0);
    do_wr  = v && ((n < DEPTH) || p);
    if (do_pop) void'(fq.pop_front());
    if (do_wr)  fq.push_back(d);
    if (pu) mon_q.push_back('{data: pd, err: (pd[W-1 -: 8] != ID) && (pd[W-1 -: 8] != 8'hFF)});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  // Asserted mid-cycle so a push issued this cycle never reaches the capture register.
  task automatic do_reset();
    #2;
    in_reset = 1'b1;
    rst_ni = 1'b0;
    agt_valid_i = 0; pop_i = 0; push_i = 0;
    fq.delete();
    mon_q.delete();
    last_mon = '0;
    #1;
    chk("rst_count", W'(count_o), '0);
    chk("rst_pndng", W'(pndng_o), '0);
    chk("rst_d_pop", d_pop_o, '0);
    chk("rst_ready", W'(agt_ready_o), 1);
    chk("rst_mon_valid", W'(mon_valid_o), '0);
    chk("rst_mon_data", mon_data_o, '0);
    chk("rst_mon_dest", W'(mon_dest_o), '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    in_reset = 1'b0;
  endtask

  // Monitor: every beat must match the oldest expected push; silent cycles hold the last word.
  initial begin
    beat_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!in_reset) begin
        if (mon_valid_o) begin
          if (mon_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL mon_spurious: got %h expected no beat", mon_data_o);
          end else begin
            e = mon_q.pop_front();
            chk("mon_data", mon_data_o, e.data);
            chk("mon_dest", W'(mon_dest_o), W'(e.data[W-1 -: 8]));
`ifdef DRV_MON_ADDR_CHECK_EN
            chk("mon_err", W'(mon_err_o), W'(e.err));
`endif
            last_mon = e.data;
          end
        end else begin
          chk("mon_missing", W'(mon_q.size()), '0);
          chk("mon_hold", mon_data_o, last_mon);
`ifdef DRV_MON_ADDR_CHECK_EN
          chk("mon_err_idle", W'(mon_err_o), '0);
`endif
        end
      end
    end
  end

  initial begin
    logic [W-1:0] pd;
    rst_ni = 1'b0;
    agt_valid_i = 0; agt_data_i = '0; pop_i = 0; push_i = 0; d_push_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    in_reset = 1'b0;
    idle(2);

    // Single write, held head, then pop to empty.
    step(1'b1, 32'h0100_0005, 1'b0, 1'b0, '0);
    idle(4);
    step(1'b0, '0, 1'b1, 1'b0, '0);
    idle(1);
    // Pop while empty is ignored.
    step(1'b0, '0, 1'b1, 1'b0, '0);
    idle(1);

    // Single push, then back-to-back pushes.
    step(1'b0, '0, 1'b0, 1'b1, 32'd2);
    idle(2);
    step(1'b0, '0, 1'b0, 1'b1, 32'h0300_0001);
    step(1'b0, '0, 1'b0, 1'b1, 32'hFF00_0001);
    step(1'b0, '0, 1'b0, 1'b1, 32'h0000_0007);
    idle(2);

    // Fill, write while full (rejected), write+pop while full, then drain.
    for (int i = 0; i < DEPTH; i++) step(1'b1, W'(i), 1'b0, 1'b0, '0);
    step(1'b1, 32'hDEAD_0000, 1'b0, 1'b0, '0);
    step(1'b1, 32'hABCD_0000, 1'b1, 1'b0, '0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0, '0);
    idle(1);
    // Write+pop on empty: only the write lands.
    step(1'b1, 32'h0000_0042, 1'b1, 1'b0, '0);
    idle(1);

    // Mid-operation reset with a push in flight.
    for (int i = 0; i < 5; i++) step(1'b1, W'(32'h100 + i), 1'b0, 1'b0, '0);
    step(1'b0, '0, 1'b0, 1'b1, 32'h0500_0009);
    do_reset();
    idle(2);

    // Randomized traffic on both paths.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 2))
        0:       pd = {8'h00, 24'($urandom)};
        1:       pd = {8'hFF, 24'($urandom)};
        default: pd = $urandom;
      endcase
      step(($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 2) == 0),
           $urandom_range(0, 1) == 1, pd);
    end
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, '0, 1'b1, 1'b0, '0);
    idle(3);
    chk("mon_drained", W'(mon_q.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
